// File: rtl/hack_alu_mc.sv
// hack_alu_mc: handshaked Hack ALU with a registered result and carry flag,
// plus a shift-add unsigned multiply mode that uses one cycle per bit.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake; x, y, ctrl, mul captured on transfer
//   x, y                WIDTH-bit operands
//   ctrl                {zx,nx,zy,ny,f,no}
//   mul                 1 selects multiply mode
//   out_valid/out_ready result handshake
//   out, zr, ng, cf     registered result and flags
module hack_alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             no_q, no_d;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_d;
  logic             cf_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] xp, yp;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hack_r;
  logic [PW-1:0]    acc_step;
  logic             last_iter;

  // Operand preprocessing: optional zero, then optional invert.
  function automatic logic [WIDTH-1:0] prep(input logic [WIDTH-1:0] v,
                                            input logic z, input logic n);
    logic [WIDTH-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  // Ready depends only on state and the output slot, never on in_valid.
  assign in_ready = !rst && (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign xp        = prep(x, ctrl[5], ctrl[4]);
  assign yp        = prep(y, ctrl[3], ctrl[2]);
  assign sum       = {1'b0, xp} + {1'b0, yp};
  assign hack_r    = ctrl[1] ? sum[WIDTH-1:0] : (xp & yp);
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Next-state and result-load logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    no_d     = no_q;
    load     = 1'b0;
    out_d    = out;
    cf_d     = cf;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mul) begin
            mcand_d  = {{WIDTH{1'b0}}, xp};
            mplier_d = yp;
            acc_d    = '0;
            cnt_d    = '0;
            no_d     = ctrl[0];
            state_d  = MUL;
          end else begin
            load  = 1'b1;
            out_d = ctrl[0] ? ~hack_r : hack_r;
            cf_d  = ctrl[1] & sum[WIDTH];
          end
        end
      end
      MUL: begin
        // Multiplier bits consumed LSB first; multiplicand shifts up to match.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          load    = 1'b1;
          out_d   = no_q ? ~acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
          cf_d    = |acc_step[PW-1:WIDTH];
          state_d = IDLE;
        end
      end
    endcase

    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
  end

  // State and result registers; result/flags only change on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      no_q      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cf        <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      no_q      <= no_d;
      out_valid <= out_valid_d;
      if (load) begin
        out <= out_d;
        zr  <= (out_d == '0);
        ng  <= out_d[WIDTH-1];
        cf  <= cf_d;
      end
    end
  end

endmodule
